// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if
//
// Bundles the signals of the writeback stage: the two execution-slot push
// handshakes, the register-file write port, the hazard query and the
// occupancy count.
//
//   slot0_*/slot1_*             valid/addr/data from the slots, ready back to them
//   destination_register        write data to the register file
//   selectDestinationRegister   write index to the register file
//   WriteMode                   write enable to the register file
//   query_addr/query_pending    RAW hazard lookup against buffered writes
//   count                       current buffer occupancy
//
// master: the side that issues results and queries (execution/issue logic).
// slave : the writeback arbiter itself.
interface writeback_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
);
  localparam int COUNT_WIDTH = $clog2(DEPTH) + 1;

  logic                   slot0_valid;
  logic [ADDR_WIDTH-1:0]  slot0_addr;
  logic [DATA_WIDTH-1:0]  slot0_data;
  logic                   slot0_ready;

  logic                   slot1_valid;
  logic [ADDR_WIDTH-1:0]  slot1_addr;
  logic [DATA_WIDTH-1:0]  slot1_data;
  logic                   slot1_ready;

  logic [DATA_WIDTH-1:0]  destination_register;
  logic [ADDR_WIDTH-1:0]  selectDestinationRegister;
  logic                   WriteMode;

  logic [ADDR_WIDTH-1:0]  query_addr;
  logic                   query_pending;

  logic [COUNT_WIDTH-1:0] count;

  modport master (
    output slot0_valid, slot0_addr, slot0_data,
    output slot1_valid, slot1_addr, slot1_data,
    output query_addr,
    input  slot0_ready, slot1_ready,
    input  destination_register, selectDestinationRegister, WriteMode,
    input  query_pending, count
  );

  modport slave (
    input  slot0_valid, slot0_addr, slot0_data,
    input  slot1_valid, slot1_addr, slot1_data,
    input  query_addr,
    output slot0_ready, slot1_ready,
    output destination_register, selectDestinationRegister, WriteMode,
    output query_pending, count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//
// Two-slot writeback stage in front of the single-write-port register file.
// Results from both execution slots are queued in an in-order FIFO
// (slot0 ahead of slot1 within a cycle) and drained one per cycle onto the
// register file write port. A combinational lookup reports whether a given
// register still has a write buffered, for RAW-hazard stalls at issue.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; empties the FIFO and idles the write port
//   wb     writeback_arbiter_if.slave (slot handshakes, write port, query, count)
module writeback_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input logic               clk,
  input logic               reset,
  writeback_arbiter_if.slave wb
);
  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam int COUNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] SLOT0_LIMIT = COUNT_WIDTH'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] SLOT1_LIMIT = COUNT_WIDTH'(DEPTH - 2);

  logic [ADDR_WIDTH-1:0]  mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_data [DEPTH];

  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   slot1_ptr;
  logic [COUNT_WIDTH-1:0] count_q;

  logic                   push0;
  logic                   push1;
  logic                   pop;

  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  sel_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   query_hit;

  // Readiness looks only at the registered count so it never forms a
  // combinational loop with the slots' valid signals. Slot1 needs room for
  // two entries because slot0 may push in the same cycle.
  assign wb.slot0_ready = !reset && (count_q <= SLOT0_LIMIT);
  assign wb.slot1_ready = !reset && (count_q <= SLOT1_LIMIT);

  assign push0 = wb.slot0_valid && wb.slot0_ready;
  assign push1 = wb.slot1_valid && wb.slot1_ready;
  assign pop   = (count_q != '0);

  // Slot1 lands behind slot0 when both push, otherwise it takes the tail.
  assign slot1_ptr = wr_ptr + PTR_WIDTH'(push0);

  // Entry storage carries no reset; occupancy is defined by count/rd_ptr.
  always_ff @(posedge clk) begin
    if (push0) begin
      mem_addr[wr_ptr] <= wb.slot0_addr;
      mem_data[wr_ptr] <= wb.slot0_data;
    end
    if (push1) begin
      mem_addr[slot1_ptr] <= wb.slot1_addr;
      mem_data[slot1_ptr] <= wb.slot1_data;
    end
  end

  // Pop uses the pre-edge count, so an entry pushed at this edge is never
  // popped at the same edge. Data/index hold their value on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_WIDTH'(push0) + PTR_WIDTH'(push1);
      count_q <= count_q + COUNT_WIDTH'(push0) + COUNT_WIDTH'(push1)
                 - COUNT_WIDTH'(pop);
      we_q    <= pop;
      if (pop) begin
        sel_q  <= mem_addr[rd_ptr];
        data_q <= mem_data[rd_ptr];
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
    end
  end

  // An entry is occupied when its distance from the head, modulo DEPTH, is
  // below the count. The entry sitting in the output registers is not
  // included: it reaches the register file during the current cycle.
  always_comb begin : query_lookup
    logic [PTR_WIDTH-1:0] slot_offset;
    slot_offset = '0;
    query_hit   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_offset = PTR_WIDTH'(i) - rd_ptr;
      if ((COUNT_WIDTH'(slot_offset) < count_q) &&
          (mem_addr[i] == wb.query_addr)) begin
        query_hit = 1'b1;
      end
    end
  end

  assign wb.query_pending             = query_hit;
  assign wb.WriteMode                 = we_q;
  assign wb.selectDestinationRegister = sel_q;
  assign wb.destination_register      = data_q;
  assign wb.count                     = count_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//
// Directed bench for writeback_arbiter. Each cycle drives both slots and the
// query address, checks readys and query_pending before the edge, then
// checks the write port and count just after the edge against a queue
// model of the buffered writes, plus hand-computed constants at key points.
module tb_writeback_arbiter;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 4;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic clk;
  logic reset;

  writeback_arbiter_if #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) bus ();

  writeback_arbiter #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .wb   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  entry_t                model_q[$];
  logic                  exp_we;
  logic [ADDR_WIDTH-1:0] exp_sel;
  logic [DATA_WIDTH-1:0] exp_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison passes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive, check pre-edge outputs, clock, update the model,
  // check post-edge outputs.
  task automatic applyStimulus(input logic rst,
                               input logic v0, input logic [ADDR_WIDTH-1:0] a0,
                               input logic [DATA_WIDTH-1:0] d0,
                               input logic v1, input logic [ADDR_WIDTH-1:0] a1,
                               input logic [DATA_WIDTH-1:0] d1,
                               input logic [ADDR_WIDTH-1:0] qa);
    logic   exp_r0;
    logic   exp_r1;
    logic   exp_pend;
    entry_t ent;
    reset           = rst;
    bus.slot0_valid = v0;
    bus.slot0_addr  = a0;
    bus.slot0_data  = d0;
    bus.slot1_valid = v1;
    bus.slot1_addr  = a1;
    bus.slot1_data  = d1;
    bus.query_addr  = qa;
    exp_r0   = !rst && (model_q.size() <= DEPTH - 1);
    exp_r1   = !rst && (model_q.size() <= DEPTH - 2);
    exp_pend = 1'b0;
    foreach (model_q[i]) if (model_q[i].addr == qa) exp_pend = 1'b1;
    #1;
    checkOutput("slot0_ready", 64'(bus.slot0_ready), 64'(exp_r0));
    checkOutput("slot1_ready", 64'(bus.slot1_ready), 64'(exp_r1));
    if (!rst) checkOutput("query_pending", 64'(bus.query_pending), 64'(exp_pend));
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
      exp_we   = 1'b0;
      exp_sel  = '0;
      exp_data = '0;
    end else begin
      if (model_q.size() > 0) begin
        ent      = model_q.pop_front();
        exp_we   = 1'b1;
        exp_sel  = ent.addr;
        exp_data = ent.data;
      end else begin
        exp_we = 1'b0;
      end
      if (v0 && exp_r0) model_q.push_back('{addr: a0, data: d0});
      if (v1 && exp_r1) model_q.push_back('{addr: a1, data: d1});
    end
    checkOutput("WriteMode", 64'(bus.WriteMode), 64'(exp_we));
    checkOutput("selectDestinationRegister", 64'(bus.selectDestinationRegister), 64'(exp_sel));
    checkOutput("destination_register", bus.destination_register, exp_data);
    checkOutput("count", 64'(bus.count), 64'(model_q.size()));
  endtask

  task automatic idleCycle(input logic [ADDR_WIDTH-1:0] qa);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, qa);
  endtask

  initial begin
    int pushed;
    int seq;
    int iter;
    logic r0, r1, v0, v1;
    logic [DATA_WIDTH-1:0] d0, d1;

    reset = 1'b1;
    bus.slot0_valid = 1'b0; bus.slot0_addr = '0; bus.slot0_data = '0;
    bus.slot1_valid = 1'b0; bus.slot1_addr = '0; bus.slot1_data = '0;
    bus.query_addr  = '0;
    exp_we = 1'b0; exp_sel = '0; exp_data = '0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b1, 5'd9, 64'h1, 1'b1, 5'd9, 64'h2, 5'd0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd0);
    checkOutput("rst_count", 64'(bus.count), 64'd0);
    checkOutput("rst_we", 64'(bus.WriteMode), 64'd0);

    $display("[TB] single push, latency and query");
    applyStimulus(1'b0, 1'b1, 5'd5, 64'hAAAA, 1'b0, '0, '0, 5'd5);
    checkOutput("t1_we_edge1", 64'(bus.WriteMode), 64'd0);
    checkOutput("t1_pend_edge1", 64'(bus.query_pending), 64'd1);
    checkOutput("t1_count_edge1", 64'(bus.count), 64'd1);
    idleCycle(5'd5);
    checkOutput("t1_we_edge2", 64'(bus.WriteMode), 64'd1);
    checkOutput("t1_sel_edge2", 64'(bus.selectDestinationRegister), 64'd5);
    checkOutput("t1_data_edge2", bus.destination_register, 64'hAAAA);
    checkOutput("t1_pend_edge2", 64'(bus.query_pending), 64'd0);
    idleCycle(5'd5);
    checkOutput("t1_we_edge3", 64'(bus.WriteMode), 64'd0);

    $display("[TB] dual push to same register");
    applyStimulus(1'b0, 1'b1, 5'd3, 64'h11, 1'b1, 5'd3, 64'h22, 5'd3);
    checkOutput("t2_count_a", 64'(bus.count), 64'd2);
    idleCycle(5'd3);
    checkOutput("t2_sel_a", 64'(bus.selectDestinationRegister), 64'd3);
    checkOutput("t2_data_a", bus.destination_register, 64'h11);
    checkOutput("t2_count_b", 64'(bus.count), 64'd1);
    idleCycle(5'd3);
    checkOutput("t2_we_b", 64'(bus.WriteMode), 64'd1);
    checkOutput("t2_data_b", bus.destination_register, 64'h22);
    checkOutput("t2_count_c", 64'(bus.count), 64'd0);
    idleCycle(5'd3);

    $display("[TB] sustained dual push");
    pushed = 0;
    seq    = 100;
    iter   = 0;
    while (pushed < 20 && iter < 60) begin
      r0 = (model_q.size() <= DEPTH - 1);
      r1 = (model_q.size() <= DEPTH - 2);
      v0 = (pushed < 20);
      d0 = 64'(seq);
      v1 = ((pushed + ((v0 && r0) ? 1 : 0)) < 20);
      d1 = 64'(seq + ((v0 && r0) ? 1 : 0));
      applyStimulus(1'b0, v0, 5'(d0), d0, v1, 5'(d1), d1, 5'(seq + 1));
      if (v0 && r0) begin pushed++; seq++; end
      if (v1 && r1) begin pushed++; seq++; end
      iter++;
    end
    checkOutput("t3_all_pushed", 64'(pushed), 64'd20);
    for (int i = 0; i < 6; i++) idleCycle(5'd0);
    checkOutput("t3_drained_count", 64'(bus.count), 64'd0);

    $display("[TB] pointer wrap with idle gaps");
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0)
        applyStimulus(1'b0, 1'b1, 5'(i + 10), 64'(32'hC0DE0000 + i), 1'b0, '0, '0, 5'(i + 10));
      else
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'(i + 10), 64'(32'hC0DE0000 + i), 5'(i + 10));
      idleCycle(5'(i + 10));
      checkOutput("t4_wrap_data", bus.destination_register, 64'(32'hC0DE0000 + i));
    end
    idleCycle(5'd0);

    $display("[TB] reset with buffered entries");
    applyStimulus(1'b0, 1'b1, 5'd7, 64'h70, 1'b1, 5'd8, 64'h80, 5'd9);
    applyStimulus(1'b0, 1'b1, 5'd9, 64'h90, 1'b1, 5'd10, 64'hA0, 5'd9);
    checkOutput("t5_count_before", 64'(bus.count), 64'd3);
    applyStimulus(1'b1, 1'b1, 5'd11, 64'hB0, 1'b1, 5'd12, 64'hC0, 5'd9);
    checkOutput("t5_we_after_reset", 64'(bus.WriteMode), 64'd0);
    checkOutput("t5_count_after_reset", 64'(bus.count), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("t5_r0_release", 64'(bus.slot0_ready), 64'd1);
    checkOutput("t5_r1_release", 64'(bus.slot1_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      idleCycle(5'd9);
      checkOutput("t5_no_stale_write", 64'(bus.WriteMode), 64'd0);
    end

    $display("[TB] write to register 0");
    applyStimulus(1'b0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, '0, 5'd0);
    idleCycle(5'd0);
    checkOutput("t6_we", 64'(bus.WriteMode), 64'd1);
    checkOutput("t6_sel", 64'(bus.selectDestinationRegister), 64'd0);
    checkOutput("t6_data", bus.destination_register, 64'hFFFF_FFFF_FFFF_FFFF);
    idleCycle(5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Two-slot VLIW writeback stage directly upstream of the 32x64 register file. It accepts results from two execution slots per cycle, buffers them in a small in-order FIFO, and drains one entry per cycle onto the register file's single write port (`destination_register`, `selectDestinationRegister`, `WriteMode`). It also reports whether a given register still has a write in flight, so issue logic can stall on RAW hazards.

## Interface
Parameters:
- DATA_WIDTH, 64, result width; matches register width.
- ADDR_WIDTH, 5, register index width (32 registers).
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- slot0_valid  in  1  slot 0 presents a result.
- slot0_addr  in  ADDR_WIDTH  slot 0 destination register.
- slot0_data  in  DATA_WIDTH  slot 0 result.
- slot0_ready  out  1  slot 0 may push this cycle.
- slot1_valid, slot1_addr, slot1_data  in  1/ADDR_WIDTH/DATA_WIDTH  same meaning for slot 1.
- slot1_ready  out  1  slot 1 may push this cycle.
- destination_register  out  DATA_WIDTH  write data to register file (registered).
- selectDestinationRegister  out  ADDR_WIDTH  write index (registered).
- WriteMode  out  1  write enable to register file (registered).
- query_addr  in  ADDR_WIDTH  register index to check for hazards.
- query_pending  out  1  combinational; 1 if any valid FIFO entry targets query_addr.
- count  out  clog2(DEPTH)+1  current FIFO occupancy (registered).

## Operation
- FIFO storage: DEPTH entries of {addr, data}, read and write pointers that wrap modulo DEPTH, and an occupancy counter.
- Ready rules use registered `count` only and never depend on valid:
  - `slot0_ready = !reset && count <= DEPTH-1`.
  - `slot1_ready = !reset && count <= DEPTH-2`.
- Push: a slot pushes when valid & ready at the clock edge.
  - Same-cycle pushes enqueue slot0 first, then slot1.
  - If both target the same address, both writes occur in that order, so slot1's value is final.
  - A slot1 push with no slot0 push takes a single entry.
- Pop: at each edge where `count > 0` before the edge, the head entry is loaded into the output registers and `WriteMode` is set to 1. Otherwise `WriteMode` is set to 0; data and index hold their last values.
- Occupancy update: count_next = count + pushes (0..2) − pop (0..1). Push and pop in the same edge are legal, including when full: when full, both readys are 0, so no push occurs.
- The pop decision uses pre-edge `count`. An entry pushed at edge E cannot be popped at edge E.
- All register indices, including 0, are written. No entry is dropped or reordered.
- `query_pending` compares `query_addr` against every occupied FIFO entry. It does not cover the entry currently in the output registers, because that write lands in the register file during the cycle `WriteMode` is high.
- Reset:
  - FIFO is emptied and `count` = 0.
  - `WriteMode` = 0, `destination_register` = 0, `selectDestinationRegister` = 0.
  - Both readys are 0 while `reset` is high; inputs are ignored.
- Reset mid-operation: all buffered entries are discarded, `WriteMode` is 0 from the next edge, and no partial write is emitted.

## Timing
- Accept at edge E, FIFO empty before it: popped at edge E+1, `WriteMode` = 1 during cycle E+1→E+2. Accept-to-write latency is 2 edges.
- Throughput: 1 register write per cycle sustained; input bursts of 2 per cycle are absorbed up to DEPTH.
- Readys reflect `count` from the previous edge. A pop at edge E frees space visible to ready only after E.
- `query_pending` is purely combinational from `query_addr` and registered FIFO state; there is no path from the valid inputs.
- First cycle after reset deasserts: `count` = 0, both readys = 1.

## Test plan
- Reset, then slot0 pushes {addr 5, data 0xAAAA} at edge 1. Required: `WriteMode` = 1 with index 5 and data 0xAAAA in cycle after edge 2. `WriteMode` = 0 otherwise. `query_pending(5)` = 1 only between edges 1 and 2.
- Both slots push at the same edge: {3, 0x11} and {3, 0x22}. Required: consecutive writes to index 3, with 0x11 then 0x22. `count` goes 2→1→0.
- Both slots push every cycle with DEPTH = 4. Required:
  - `slot1_ready` drops when `count` ≥ 3 and `slot0_ready` drops at `count` = 4.
  - Exactly one write per cycle.
  - No loss or reordering over 20 pushes, checked against a scoreboard model.
- Pointer wrap: 9 single pushes with idle gaps. Required: output order and data match input order across the pointer wrap.
- Assert `reset` while 3 entries are buffered. Required:
  - `WriteMode` = 0 and `count` = 0 after that edge.
  - Readys are 0 during reset and 1 the cycle after release.
  - No stale entry is written afterwards.
- Push to register 0 with data 0xFFFFFFFFFFFFFFFF. Required: the write is emitted with index 0; it is not suppressed.
